mac_result_stage: RTL and testbench



---
 rtl/mac_result_stage.sv | 119 +++++++++++
 tb/tb_mac_result_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mac_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_stage
// Brief    : MAC output stage. Buffers rounded results in a 2-entry
//            valid/ready FIFO, packs them into an IEEE-754 word (canonical
//            NaN on invalid) and keeps the sticky RISC-V fflags accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module mac_result_stage #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter logic [PARM_EXP+PARM_MANT:0] PARM_CANON_NAN = 32'h7FC0_0000
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          In_valid_i,
  output logic                          In_ready_o,
  input  logic                          Sign_i,
  input  logic [PARM_EXP-1:0]           Exp_i,
  input  logic [PARM_MANT-1:0]          Mant_i,
  input  logic                          Invalid_i,
  input  logic                          Overflow_i,
  input  logic                          Underflow_i,
  input  logic                          Inexact_i,
  input  logic                          Flush_i,
  output logic                          Out_valid_o,
  input  logic                          Out_ready_i,
  output logic [PARM_EXP+PARM_MANT:0]   Result_o,
  output logic [4:0]                    Fflags_o,
  input  logic                          Csr_we_i,
  input  logic [4:0]                    Csr_wdata_i,
  output logic [4:0]                    Fflags_acc_o
);

  localparam int          W        = PARM_EXP + PARM_MANT + 1;
  localparam logic [1:0]  C_FULL   = 2'd2;
  localparam logic [1:0]  C_EMPTY  = 2'd0;

  logic [W-1:0] data_q  [2];
  logic [4:0]   flags_q [2];
  logic [1:0]   count_q, count_d;
  logic         wptr_q,  wptr_d;
  logic         rptr_q,  rptr_d;
  logic [4:0]   acc_q,   acc_d;

  logic         push, pop, wr_en;
  logic [W-1:0] push_word;
  logic [4:0]   push_flags;
  logic [4:0]   head_flags;

  // Handshake flags come from registered count only, so no input->output path.
  assign In_ready_o  = (count_q != C_FULL);
  assign Out_valid_o = (count_q != C_EMPTY);
  assign push        = In_valid_i & In_ready_o;
  assign pop         = Out_valid_o & Out_ready_i;
  // A push coinciding with a flush is dropped.
  assign wr_en       = push & ~Flush_i;

  // Invalid dominates: the other exceptions are masked and the word is the canonical NaN.
  assign push_word  = Invalid_i ? PARM_CANON_NAN : {Sign_i, Exp_i, Mant_i};
  assign push_flags = {Invalid_i,
                       1'b0,
                       Overflow_i & ~Invalid_i,
                       Underflow_i & ~Invalid_i,
                       (Inexact_i | Overflow_i | Underflow_i) & ~Invalid_i};

  assign head_flags   = flags_q[rptr_q];
  assign Result_o     = Out_valid_o ? data_q[rptr_q] : '0;
  assign Fflags_o     = Out_valid_o ? head_flags     : 5'b0;
  assign Fflags_acc_o = acc_q;

  // Next-state for occupancy, pointers and the sticky accumulator.
  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    acc_d   = (Csr_we_i ? Csr_wdata_i : acc_q) | (pop ? head_flags : 5'b0);
    if (Flush_i) begin
      count_d = C_EMPTY;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= C_EMPTY;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      acc_q   <= 5'b0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      acc_q   <= acc_d;
    end
  end

  // Entry storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i]  <= '0;
        flags_q[i] <= 5'b0;
      end
    end else if (wr_en) begin
      data_q[wptr_q]  <= push_word;
      flags_q[wptr_q] <= push_flags;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_result_stage
// Brief    : Directed self-checking bench for mac_result_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign = 1'b0;
  logic [7:0]  expo = 8'h0;
  logic [22:0] mant = 23'h0;
  logic        inv = 1'b0, ovf = 1'b0, unf = 1'b0, inx = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  fflags;
  logic        csr_we = 1'b0;
  logic [4:0]  csr_wdata = 5'b0;
  logic [4:0]  acc;

  int checks = 0;
  int errors = 0;

  mac_result_stage dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .In_valid_i   (in_valid),
    .In_ready_o   (in_ready),
    .Sign_i       (sign),
    .Exp_i        (expo),
    .Mant_i       (mant),
    .Invalid_i    (inv),
    .Overflow_i   (ovf),
    .Underflow_i  (unf),
    .Inexact_i    (inx),
    .Flush_i      (flush),
    .Out_valid_o  (out_valid),
    .Out_ready_i  (out_ready),
    .Result_o     (result),
    .Fflags_o     (fflags),
    .Csr_we_i     (csr_we),
    .Csr_wdata_i  (csr_wdata),
    .Fflags_acc_o (acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] word,
                        input logic i, input logic o, input logic u, input logic x);
    in_valid = v;
    {sign, expo, mant} = word;
    inv = i; ovf = o; unf = u; inx = x;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_result",    result,             32'h0);
    chk("rst_fflags",    {27'b0, fflags},    32'd0);
    chk("rst_acc",       {27'b0, acc},       32'd0);
    #5 rst_n = 1'b1;

    // Single result: first edge after reset accepts, visible next cycle
    set_in(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_valid",  {31'b0, out_valid}, 32'd1);
    chk("single_result", result,             32'h3F80_0000);
    chk("single_flags",  {27'b0, fflags},    32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_acc",    {27'b0, acc},       32'd0);
    chk("single_empty",  {31'b0, out_valid}, 32'd0);

    // Invalid substitution: sign=1, exp=FF, overflow masked
    set_in(1'b1, 32'hFF80_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("nan_result", result,          32'h7FC0_0000);
    chk("nan_flags",  {27'b0, fflags}, 32'h10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("nan_acc",    {27'b0, acc},    32'h10);

    // Backpressure / full
    set_in(1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    chk("full_head_A",   result,            32'h4000_0000);
    tick();
    chk("stall_head_A",  result,            32'h4000_0000);
    out_ready = 1'b1;
    tick();
    chk("drain_head_B",  result,            32'h4040_0000);
    chk("drain_ready",   {31'b0, in_ready}, 32'd1);
    tick();
    out_ready = 1'b0;
    chk("drain_empty",   {31'b0, out_valid}, 32'd0);
    chk("drain_acc",     {27'b0, acc},       32'h10);

    // Accumulation and CSR
    csr_we = 1'b1; csr_wdata = 5'b0;
    tick();
    csr_we = 1'b0;
    chk("csr_clear", {27'b0, acc}, 32'd0);
    set_in(1'b1, 32'h7F00_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("ovf_flags", {27'b0, fflags}, 32'h05);
    // Pop overflow result while pushing an inexact one
    set_in(1'b1, 32'h3F80_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b1;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_acc",   {27'b0, acc},    32'h05);
    chk("nx_flags",  {27'b0, fflags}, 32'h01);
    chk("nx_result", result,          32'h3F80_0001);
    // CSR write of 0 coincident with pop of the inexact result
    csr_we = 1'b1; csr_wdata = 5'b0;
    tick();
    csr_we = 1'b0; out_ready = 1'b0;
    chk("csr_pop_acc", {27'b0, acc}, 32'h01);

    // Flush with two entries held, coincident push and pop
    set_in(1'b1, 32'h0080_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 32'h4080_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_flush_full", {31'b0, in_ready}, 32'd0);
    set_in(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_acc",      {27'b0, acc},       32'h03);
    chk("flush_valid",    {31'b0, out_valid}, 32'd0);
    chk("flush_ready",    {31'b0, in_ready},  32'd1);
    chk("flush_result",   result,             32'h0);
    tick();
    chk("flush_no_ghost", {31'b0, out_valid}, 32'd0);

    // Async reset mid-operation
    set_in(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    csr_we = 1'b1; csr_wdata = 5'b11111;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    csr_we = 1'b0;
    chk("pre_rst_acc",   {27'b0, acc},       32'h1F);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_acc",   {27'b0, acc},       32'd0);
    chk("arst_ready", {31'b0, in_ready},  32'd1);
    chk("arst_result", result,            32'h0);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
